// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_responder_pkg: shared types and widths for the memory responder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CNT_W      = 4;
  localparam int RSP_DATA_W = 64;
  localparam int RSP_ERR_W  = 1;

endpackage

`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
// ---------------------------------------------------------------------------
// mem_array: DEPTH x XLEN synchronous RAM, byte-strobed write, registered read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_array #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4096
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     wen_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [XLEN/8-1:0]        mask_i,
  output logic [XLEN-1:0]          rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !wen_i) begin
      rdata_d = mem_q[idx_i];
    end
  end

  // Contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
    if (en_i && wen_i) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (mask_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder: one-at-a-time valid/ready memory responder, programmable latency
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
  parameter int                XLEN    = 64,
  parameter int                ADDR_W  = 32,
  parameter int                DEPTH   = 4096,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
  parameter int                LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_wen_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [XLEN/8-1:0] req_mask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o
);
  import mem_responder_pkg::*;

  localparam int                BYTES   = XLEN / 8;
  localparam int                OFF_W   = $clog2(BYTES);
  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   BASE_X  = {1'b0, BASE};
  localparam logic [ADDR_W:0]   LIMIT_X = BASE_X + (ADDR_W+1)'(DEPTH * BYTES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [BYTES-1:0]    mask_q, mask_d;

  logic                access;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_wen;
  logic [XLEN-1:0]     acc_wdata;
  logic [BYTES-1:0]    acc_mask;
  logic                ram_en;
  logic [XLEN-1:0]     ram_rdata;
  logic                rsp_in_range;

  // One extra bit so BASE + size cannot wrap.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ax;
    ax = {1'b0, a};
    return (ax >= BASE_X) && (ax < LIMIT_X);
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return off[OFF_W +: IDX_W];
  endfunction

  assign req_ready_o = (state_q == ST_IDLE) && !rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          addr_d  = req_addr_i;
          wen_d   = req_wen_i;
          wdata_d = req_wdata_i;
          mask_d  = req_mask_i;
          if (LATENCY == 0) begin
            state_d = ST_RESP;
            cnt_d   = '0;
            access  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          access  = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero latency the access happens on the accepting edge, before the latches hold the request.
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr_i  : addr_q;
  assign acc_wen   = (state_q == ST_IDLE) ? req_wen_i   : wen_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata_i : wdata_q;
  assign acc_mask  = (state_q == ST_IDLE) ? req_mask_i  : mask_q;
  assign ram_en    = access && !rst_i && in_range(acc_addr);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
    end
  end

  mem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .wen_i   (acc_wen),
    .idx_i   (idx_of(acc_addr)),
    .wdata_i (acc_wdata),
    .mask_i  (acc_mask),
    .rdata_o (ram_rdata)
  );

  assign rsp_in_range = in_range(addr_q);
  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_err_o    = rsp_valid_o && !rsp_in_range;
  assign rsp_rdata_o  = (rsp_valid_o && rsp_in_range && !wen_q) ? ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder: directed table plus randomized checks for mem_responder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  localparam int N = 3;
  typedef longint unsigned u64_t;
  localparam u64_t BASE_U = 64'h8000_0000;
  localparam u64_t SIZE_U = 64'd4096 * 64'd8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [N];
  logic        req_ready [N];
  logic [31:0] req_addr  [N];
  logic        req_wen   [N];
  logic [63:0] req_wdata [N];
  logic [7:0]  req_mask  [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [63:0] rsp_rdata [N];
  logic        rsp_err   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .XLEN    (64),
      .ADDR_W  (32),
      .DEPTH   (4096),
      .BASE    (32'h8000_0000),
      .LATENCY (g == 0 ? 2 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_addr_i  (req_addr[g]),
      .req_wen_i   (req_wen[g]),
      .req_wdata_i (req_wdata[g]),
      .req_mask_i  (req_mask[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .rsp_err_o   (rsp_err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference memory kept as individual bytes keyed by DUT and byte address.
  byte unsigned ref_b [u64_t];

  task automatic ref_apply(input int k, input logic wen, input logic [31:0] a,
                           input logic [63:0] wd, input logic [7:0] m,
                           output logic [63:0] rd, output logic er);
    u64_t ax, wa, key;
    ax = {32'h0, a};
    rd = '0;
    er = 1'b0;
    if (ax < BASE_U || ax >= BASE_U + SIZE_U) begin
      er = 1'b1;
    end else begin
      wa = (ax / 8) * 8;
      for (int b = 0; b < 8; b++) begin
        key = (u64_t'(k) << 40) + wa + u64_t'(b);
        if (wen) begin
          if (m[b]) ref_b[key] = wd[8*b +: 8];
        end else begin
          rd[8*b +: 8] = ref_b.exists(key) ? ref_b[key] : 8'h00;
        end
      end
    end
  endtask

  task automatic txn(input int k, input logic wen, input logic [31:0] a,
                     input logic [63:0] wd, input logic [7:0] m, input int bp,
                     input logic [63:0] exp_rd, input logic exp_er);
    int c;
    int lat;
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_mask[k]  = m;
    rsp_ready[k] = (bp == 0);
    c = 0;
    while (!req_ready[k] && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("ready_before_accept", 64'(req_ready[k]), 64'd1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_wen[k]   = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = {$urandom, $urandom};
    req_mask[k]  = 8'($urandom);
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(lat_of(k) + 1));
    chk("rdata", rsp_rdata[k], exp_rd);
    chk("err", 64'(rsp_err[k]), 64'(exp_er));
    for (int i = 0; i < bp; i++) begin
      chk("bp_req_ready", 64'(req_ready[k]), 64'd0);
      @(posedge clk); #1;
      chk("bp_valid", 64'(rsp_valid[k]), 64'd1);
      chk("bp_rdata", rsp_rdata[k], exp_rd);
      chk("bp_err", 64'(rsp_err[k]), 64'(exp_er));
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    chk("post_hs_valid", 64'(rsp_valid[k]), 64'd0);
    chk("post_hs_ready", 64'(req_ready[k]), 64'd1);
  endtask

  typedef struct {
    int          k;
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    int          bp;
    logic [63:0] exp_rd;
    logic        exp_er;
  } vec_t;

  localparam int NT = 16;
  vec_t tbl [NT];

  initial begin
    logic [63:0] mrd;
    logic        mer;
    logic [31:0] a;
    logic        w;
    logic [63:0] wd;
    logic [7:0]  m;
    int          k;
    int          sel;

    tbl[0]  = '{0, 1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'h0, 1'b0};
    tbl[1]  = '{0, 1'b0, 32'h8000_0010, 64'h0, 8'h00, 0, 64'h1122_3344_5566_7788, 1'b0};
    tbl[2]  = '{0, 1'b1, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 64'h0, 1'b0};
    tbl[3]  = '{0, 1'b1, 32'h8000_0000, 64'h0, 8'h0F, 0, 64'h0, 1'b0};
    tbl[4]  = '{0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 5, 64'hFFFF_FFFF_0000_0000, 1'b0};
    tbl[5]  = '{0, 1'b1, 32'h8000_7FF8, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 0, 64'h0, 1'b0};
    tbl[6]  = '{0, 1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, 0, 64'h0, 1'b1};
    tbl[7]  = '{0, 1'b1, 32'h8000_8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 64'h0, 1'b1};
    tbl[8]  = '{0, 1'b0, 32'h8000_7FFF, 64'h0, 8'h00, 0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0};
    tbl[9]  = '{0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_0000_0000, 1'b0};
    tbl[10] = '{1, 1'b1, 32'h8000_0100, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 64'h0, 1'b0};
    tbl[11] = '{1, 1'b0, 32'h8000_0104, 64'h0, 8'h00, 2, 64'h0123_4567_89AB_CDEF, 1'b0};
    tbl[12] = '{2, 1'b1, 32'h8000_0200, 64'h5555_5555_5555_5555, 8'hFF, 0, 64'h0, 1'b0};
    tbl[13] = '{2, 1'b0, 32'h8000_0200, 64'h0, 8'h00, 1, 64'h5555_5555_5555_5555, 1'b0};
    tbl[14] = '{1, 1'b1, 32'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 1, 64'h0, 1'b0};
    tbl[15] = '{1, 1'b0, 32'h8000_0100, 64'h0, 8'h00, 0, 64'hFF23_4567_89AB_CDFF, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_wen[i] = 1'b0;
      req_wdata[i] = '0;   req_mask[i] = '0; rsp_ready[i] = 1'b0;
    end

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        chk("rst_ready", 64'(req_ready[i]), 64'd0);
        chk("rst_valid", 64'(rsp_valid[i]), 64'd0);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("idle_ready", 64'(req_ready[i]), 64'd1);
      chk("idle_valid", 64'(rsp_valid[i]), 64'd0);
      chk("idle_rdata", rsp_rdata[i], 64'd0);
      chk("idle_err", 64'(rsp_err[i]), 64'd0);
    end

    for (int t = 0; t < NT; t++) begin
      txn(tbl[t].k, tbl[t].wen, tbl[t].addr, tbl[t].wdata, tbl[t].mask,
          tbl[t].bp, tbl[t].exp_rd, tbl[t].exp_er);
      ref_apply(tbl[t].k, tbl[t].wen, tbl[t].addr, tbl[t].wdata, tbl[t].mask, mrd, mer);
    end

    // Reset while a LATENCY=3 write is still waiting: the write must be dropped.
    req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0200;
    req_wdata[2] = 64'h0; req_mask[2] = 8'hFF;
    chk("midrst_pre_ready", 64'(req_ready[2]), 64'd1);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", 64'(req_ready[2]), 64'd0);
    @(posedge clk); #1;
    chk("midrst_valid", 64'(rsp_valid[2]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 64'(req_ready[2]), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", 64'(rsp_valid[2]), 64'd0);
    end
    txn(2, 1'b0, 32'h8000_0200, 64'h0, 8'h00, 0, 64'h5555_5555_5555_5555, 1'b0);

    // Randomized traffic over a small initialized window plus out-of-range addresses.
    for (int kk = 0; kk < N; kk++) begin
      for (int wi = 0; wi < 8; wi++) begin
        a  = 32'h8000_0400 + 32'(wi * 8);
        wd = {$urandom, $urandom};
        ref_apply(kk, 1'b1, a, wd, 8'hFF, mrd, mer);
        txn(kk, 1'b1, a, wd, 8'hFF, 0, mrd, mer);
      end
    end
    for (int r = 0; r < 60; r++) begin
      k   = $urandom_range(0, N - 1);
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'h8000_0000 - 32'($urandom_range(1, 4096));
      else if (sel == 1) a = 32'h8000_8000 + 32'($urandom_range(0, 4096));
      else               a = 32'h8000_0400 + 32'($urandom_range(0, 63));
      w  = 1'($urandom);
      wd = {$urandom, $urandom};
      m  = 8'($urandom);
      ref_apply(k, w, a, wd, m, mrd, mer);
      txn(k, w, a, wd, m, $urandom_range(0, 3), mrd, mer);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's instruction-fetch and load/store request ports. It accepts one request at a time over a valid/ready request channel and performs the read or byte-strobed write against an internal word array. It returns the result over a valid/ready response channel after a programmable latency. It sits below `ifu`/`lsu` as the simulated main memory and replaces direct combinational memory access, so the core can be moved to a handshaked memory interface.

## Interface
- `XLEN`, 64: data word width in bits
- `ADDR_W`, 32: request address width
- `DEPTH`, 4096: number of XLEN words in the array
- `BASE`, 32'h8000_0000: byte address of word 0
- `LATENCY`, 2: wait cycles between acceptance and response (0–15)

- `clk_i` input 1: single clock; all state updates on rising edge
- `rst_i` input 1: reset, synchronous, active-high
- `req_valid_i` input 1: request present
- `req_ready_o` output 1: responder can accept
- `req_addr_i` input ADDR_W: byte address
- `req_wen_i` input 1: 1 = write, 0 = read
- `req_wdata_i` input XLEN: write data, word-aligned lanes
- `req_mask_i` input XLEN/8: byte strobes for writes
- `rsp_valid_o` output 1: response present
- `rsp_ready_i` input 1: requester takes response
- `rsp_rdata_o` output XLEN: read data (0 for writes and errors)
- `rsp_err_o` output 1: address outside [BASE, BASE+DEPTH*XLEN/8)

## Operation
- FSM states:
  - IDLE: `req_ready_o` = 1. Request handshake (valid & ready) latches addr, wen, wdata, and mask. Loads the wait counter with LATENCY and moves to WAIT, or to RESP if LATENCY = 0.
  - WAIT: the counter decrements each cycle. At 1 it moves to RESP on the next edge.
  - RESP: `rsp_valid_o` = 1. On `rsp_ready_i` it returns to IDLE.
- Memory access happens on the edge entering RESP:
  - Read: captures the full word at index (addr − BASE) >> log2(XLEN/8). Low address bits are ignored; alignment, extraction and sign extension stay in `lsu`.
  - Write: updates only the bytes whose mask bit is set. `rsp_rdata_o` = 0.
  - Out of range: no array access, `rsp_err_o` = 1, `rsp_rdata_o` = 0.
- Array contents are not reset. Contents are preloaded via `$readmemh` in simulation.

## Timing
- Reset (edge with `rst_i` = 1):
  - state = IDLE, `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0, counter = 0.
  - `req_ready_o` = 0 while `rst_i` is high and 1 in the first cycle after it falls.
- A request accepted in cycle T gives `rsp_valid_o` high from cycle T+LATENCY+1.
- Response payload and `rsp_valid_o` stay stable until the handshake cycle. Back-pressure of any length must be tolerated.
- `req_ready_o` goes high the cycle after the response handshake. There is no request/response overlap and no same-cycle turnaround, so at most one request is in flight.
- `req_*` inputs are sampled only in the acceptance cycle. Later changes have no effect.
- If reset is asserted mid-transaction (WAIT or RESP), the transaction is dropped. A write whose RESP edge has not yet occurred does not modify the array. No response is produced.
- Address range check:
  - Last valid byte = BASE + DEPTH*XLEN/8 − 1.
  - Compute the check in ADDR_W+1 bits so BASE+size cannot wrap.
  - An address below BASE is out of range.

## Structure
- Shared package (`defines`) gets the responder FSM state encoding (IDLE/WAIT/RESP, 2 bits), the latency counter width (4) and the response bus widths.
- One sub-module, `mem_array`: a DEPTH×XLEN synchronous RAM with a byte-strobe write port and a registered read port, instantiated once.
- The FSM, counter, latches and range check live in `mem_responder`.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst_i` 3 cycles, then release with `req_valid_i` = 0.
  - Response: `rsp_valid_o` = 0 throughout; `req_ready_o` = 0 during reset and 1 after.
- Write then read, LATENCY = 2:
  - Stimulus: write addr 0x8000_0010, wdata 0x1122334455667788, mask 0xFF; then read 0x8000_0010.
  - Response: each `rsp_valid_o` rises 3 cycles after acceptance. Read returns 0x1122334455667788 with `rsp_err_o` = 0.
- Partial write:
  - Stimulus: preload word 0 with 0xFFFF_FFFF_FFFF_FFFF; write 0x8000_0000, wdata 0, mask 0x0F; read back.
  - Response: 0xFFFF_FFFF_0000_0000.
- Back-pressure:
  - Stimulus: hold `rsp_ready_i` = 0 for 5 cycles during a read response.
  - Response: `rsp_valid_o` and `rsp_rdata_o` stay stable and `req_ready_o` stays 0 until the handshake. `req_ready_o` = 1 the next cycle.
- Out of range:
  - Stimulus: read 0x7FFF_FFF8; write 0x8000_8000 with DEPTH = 4096.
  - Response: `rsp_err_o` = 1, `rsp_rdata_o` = 0; the array is unchanged (verified by reading the last word).
- LATENCY = 0 and mid-transaction reset:
  - Stimulus: LATENCY = 0, then issue a write.
  - Response: response 1 cycle after acceptance.
  - Stimulus: LATENCY = 3, assert reset in WAIT.
  - Response: no response, target word keeps its old value, `req_ready_o` = 1 after release.
